// File: rtl/bcd_down_2digit_timer_pkg.sv
// ============================================================================
//  Module      : bcd_down_2digit_timer_pkg
//  Description : Shared widths, state encodings and digit helpers for the
//                two-digit BCD down-counting timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_down_2digit_timer_pkg;

    localparam int unsigned c_digit_w = 4;
    localparam int unsigned c_bcd_w   = 8;

    localparam logic [c_digit_w-1:0] c_digit_max = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Saturate a raw nibble to a legal decimal digit.
    function automatic logic [c_digit_w-1:0] clamp_digit(input logic [c_digit_w-1:0] d);
        return (d > c_digit_max) ? c_digit_max : d;
    endfunction

    // Saturate both nibbles of a packed value so it is always valid BCD.
    function automatic logic [c_bcd_w-1:0] clamp_bcd(input logic [c_bcd_w-1:0] v);
        return {clamp_digit(v[7:4]), clamp_digit(v[3:0])};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_down_2digit_timer_digit.sv
// ============================================================================
//  Module      : bcd_digit_down
//  Description : One BCD digit decrementer (combinational). Wraps 0 -> 9 and
//                raises borrow so the next-higher digit can decrement.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_down
    import bcd_down_2digit_timer_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       dec_i,
    output logic [3:0] digit_o,
    output logic       borrow_o
);

    // Decrement with decimal wrap; pass through when not decrementing.
    always_comb begin
        digit_o  = digit_i;
        borrow_o = 1'b0;
        if (dec_i) begin
            if (digit_i == 4'd0) begin
                digit_o  = c_digit_max;
                borrow_o = 1'b1;
            end else begin
                digit_o  = digit_i - 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_down_2digit_timer.sv
// ============================================================================
//  Module      : bcd_down_2digit_timer
//  Description : Two-digit BCD down-counting timer with start/pause/done
//                control and a one-cycle expire pulse on the terminal tick.
//                Build option BCD_DOWN_AUTO_RELOAD_EN: terminal tick reloads
//                the count from the reload register and keeps running
//                instead of entering DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_down_2digit_timer
    import bcd_down_2digit_timer_pkg::*;
#(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [7:0] q,
    output logic       running,
    output logic       done,
    output logic       expire
);

    state_t              state_q, state_d;
    logic [c_bcd_w-1:0]  count_q, count_d;
    logic [c_bcd_w-1:0]  reload_q, reload_d;
    logic                expire_q, expire_d;

    logic                w_dec;
    logic [3:0]          w_ones_next;
    logic [3:0]          w_tens_next;
    logic                w_ones_borrow;
    logic                w_unused_tens_borrow;

    // A decrement is only requested for a qualified tick on a non-zero count;
    // the zero case is the terminal tick handled by the control logic.
    assign w_dec = (state_q == S_RUN) && tick && !load && !pause && (count_q != 8'h00);

    bcd_digit_down u_ones (
        .digit_i  (count_q[3:0]),
        .dec_i    (w_dec),
        .digit_o  (w_ones_next),
        .borrow_o (w_ones_borrow)
    );

    bcd_digit_down u_tens (
        .digit_i  (count_q[7:4]),
        .dec_i    (w_ones_borrow),
        .digit_o  (w_tens_next),
        .borrow_o (w_unused_tens_borrow)
    );

    // State, count, reload and expire registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= RESET_VAL;
            reload_q <= RESET_VAL;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    // Next-state logic in priority order: load, pause, start, tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        if (load) begin
            count_d  = clamp_bcd(load_val);
            reload_d = clamp_bcd(load_val);
            state_d  = S_IDLE;
        end else if (pause && (state_q == S_RUN)) begin
            state_d  = S_PAUSE;
        end else if (start && (state_q != S_RUN)) begin
            state_d  = S_RUN;
        end else if (tick && (state_q == S_RUN)) begin
            if (count_q == 8'h00) begin
                expire_d = 1'b1;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
                count_d  = reload_q;
`else
                state_d  = S_DONE;
`endif
            end else begin
                count_d  = {w_tens_next, w_ones_next};
            end
        end
    end

`ifndef BCD_DOWN_AUTO_RELOAD_EN
    // Without auto-reload the reload register is load-written only and the
    // top digit's borrow has no consumer.
    logic w_unused_reload;
    assign w_unused_reload = ^reload_q ^ w_unused_tens_borrow;
`else
    logic w_unused_borrow;
    assign w_unused_borrow = w_unused_tens_borrow;
`endif

    assign q       = count_q;
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign expire  = expire_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_down_2digit_timer.sv
// ============================================================================
//  Module      : tb_bcd_down_2digit_timer
//  Description : Scoreboard bench for the two-digit BCD down timer. A
//                decimal reference model predicts each cycle's outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_down_2digit_timer;

    localparam logic [7:0] c_reset_val = 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] q;
    logic       running;
    logic       done;
    logic       expire;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain decimal integers.
    int m_val;
    int m_rel;
    int m_state;   // 0 idle, 1 run, 2 pause, 3 done
    bit m_expire;

    logic [10:0] sb[$];

    bcd_down_2digit_timer #(.RESET_VAL(c_reset_val)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .q        (q),
        .running  (running),
        .done     (done),
        .expire   (expire)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic int to_dec(input logic [7:0] v);
        int t;
        int o;
        t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        o = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return t * 10 + o;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    // Drive one cycle of inputs, predict the result, then compare after the edge.
    task automatic step(input bit r, input bit ld, input logic [7:0] lv,
                        input bit st, input bit pa, input bit tk, input string tag);
        logic [10:0] e;
        rst = r; load = ld; load_val = lv; start = st; pause = pa; tick = tk;
        m_expire = 0;
        if (r) begin
            m_val = to_dec(c_reset_val); m_rel = m_val; m_state = 0;
        end else if (ld) begin
            m_val = to_dec(lv); m_rel = m_val; m_state = 0;
        end else if (pa && m_state == 1) begin
            m_state = 2;
        end else if (st && m_state != 1) begin
            m_state = 1;
        end else if (tk && m_state == 1) begin
            if (m_val == 0) begin
                m_expire = 1;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
                m_val = m_rel;
`else
                m_state = 3;
`endif
            end else begin
                m_val = m_val - 1;
            end
        end
        sb.push_back({to_bcd(m_val), m_state == 1, m_state == 3, m_expire});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb"}, 8'h00, 8'h01);
        end else begin
            e = sb.pop_front();
            check({tag, ".q"},       q,              e[10:3]);
            check({tag, ".running"}, {7'd0, running}, {7'd0, e[2]});
            check({tag, ".done"},    {7'd0, done},    {7'd0, e[1]});
            check({tag, ".expire"},  {7'd0, expire},  {7'd0, e[0]});
        end
    endtask

    initial begin
        m_val = 0; m_rel = 0; m_state = 0; m_expire = 0;
        #2;
        step(1, 0, 8'h00, 0, 0, 0, "reset");
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 0, 1, "idle_tick");

        step(0, 1, 8'h12, 0, 0, 0, "load12");
        step(0, 0, 8'h00, 1, 0, 0, "start12");
        for (int i = 0; i < 13; i++) step(0, 0, 8'h00, 0, 0, 1, "count12");
        step(0, 0, 8'h00, 0, 0, 0, "after_exp");
        step(0, 0, 8'h00, 0, 0, 1, "tick_after");

        step(0, 1, 8'h20, 0, 0, 0, "load20");
        step(0, 0, 8'h00, 1, 0, 0, "start20");
        step(0, 0, 8'h00, 0, 0, 1, "borrow20");
        step(0, 1, 8'h00, 0, 0, 0, "load00");
        step(0, 0, 8'h00, 1, 0, 0, "start00");
        step(0, 0, 8'h00, 0, 0, 1, "term00");
        step(0, 0, 8'h00, 0, 0, 0, "post00");

        step(0, 1, 8'hAF, 0, 0, 0, "clampAF");
        step(0, 1, 8'hA5, 0, 0, 0, "clampA5");
        step(0, 1, 8'h3F, 0, 0, 0, "clamp3F");

        step(0, 1, 8'h05, 0, 0, 0, "load05");
        step(0, 0, 8'h00, 1, 0, 0, "start05");
        step(0, 0, 8'h00, 0, 0, 1, "t05a");
        step(0, 0, 8'h00, 0, 0, 1, "t05b");
        step(0, 0, 8'h00, 0, 1, 1, "pause_tick");
        step(0, 0, 8'h00, 0, 0, 1, "paused_tick");
        step(0, 0, 8'h00, 1, 0, 0, "restart");
        step(0, 0, 8'h00, 0, 0, 1, "t05c");

        step(0, 1, 8'h01, 0, 0, 0, "load01");
        step(0, 0, 8'h00, 1, 0, 0, "start01");
        step(0, 0, 8'h00, 0, 0, 1, "t01a");
        step(0, 0, 8'h00, 0, 0, 1, "t01term");
        step(0, 0, 8'h00, 1, 0, 0, "start_done");
        step(0, 0, 8'h00, 0, 0, 1, "t01again");

        step(0, 1, 8'h03, 0, 0, 0, "load03");
        step(0, 0, 8'h00, 1, 0, 1, "start03");
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 0, 1, "count03");
        step(1, 0, 8'h00, 0, 0, 1, "rst_term");
        step(0, 0, 8'h00, 0, 0, 0, "post_rst");

        step(0, 1, 8'h40, 0, 0, 0, "load40");
        step(0, 0, 8'h00, 1, 0, 0, "start40");
        step(0, 0, 8'h00, 0, 0, 1, "t40");
        step(0, 1, 8'h12, 0, 0, 1, "load_tick");
        step(0, 0, 8'h00, 0, 0, 1, "idle_after_load");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
